// File: rtl/bridge_fifo_pkg.sv
// bridge_fifo_pkg: default geometry shared by bridge FIFO instances
package bridge_fifo_pkg;
  localparam int DEF_DEPTH_LG2 = 4;
  localparam int DEF_DATA_WIDTH = 32;
endpackage

// File: rtl/bridge_fifo.sv
// bridge_fifo: single-clock first-word-fall-through FIFO with wrap-bit pointers
module bridge_fifo
  import bridge_fifo_pkg::*;
#(
  parameter int DEPTH_LG2 = DEF_DEPTH_LG2,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  full_o,
  output logic                  empty_o,
  input  logic                  wren_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  rden_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);
  localparam int DEPTH = 2 ** DEPTH_LG2;
  localparam logic [DEPTH_LG2:0] ONE = 1;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH_LG2:0] wr_ptr, rd_ptr;
  logic push, pop;
  assign empty_o = wr_ptr == rd_ptr;
  assign full_o = (wr_ptr[DEPTH_LG2] != rd_ptr[DEPTH_LG2]) &&
                  (wr_ptr[DEPTH_LG2-1:0] == rd_ptr[DEPTH_LG2-1:0]);
  assign push = wren_i && !full_o;
  assign pop = rden_i && !empty_o;
  assign rdata_o = mem[rd_ptr[DEPTH_LG2-1:0]];
  // pointer advance and storage write; reset wipes contents immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[DEPTH_LG2-1:0]] <= wdata_i;
        wr_ptr <= wr_ptr + ONE;
      end
      if (pop) rd_ptr <= rd_ptr + ONE;
    end
  end
endmodule

// File: tb/tb_bridge_fifo.sv
// tb_bridge_fifo: queue-model scoreboard plus directed literal checks for bridge_fifo
module tb_bridge_fifo;
  logic clk = 0, rst_n;
  logic full_o, empty_o, wren_i = 0, rden_i = 0;
  logic [31:0] wdata_i = 0, rdata_o;
  int total = 0, bad = 0;
  logic [31:0] q[$];

  bridge_fifo #(.DEPTH_LG2(4), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .full_o(full_o), .empty_o(empty_o),
    .wren_i(wren_i), .wdata_i(wdata_i), .rden_i(rden_i), .rdata_o(rdata_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: occupancy decisions use the queue size before the edge
  always @(posedge clk) begin
    if (rst_n === 1'b1) begin
      automatic bit p = wren_i && q.size() < 16;
      automatic bit o = rden_i && q.size() > 0;
      if (o) void'(q.pop_front());
      if (p) q.push_back(wdata_i);
    end
  end
  always @(negedge rst_n) q.delete();

  // per-cycle compare against the model
  always @(negedge clk) begin
    chk("m_empty", {31'b0, empty_o}, {31'b0, q.size() == 0});
    chk("m_full", {31'b0, full_o}, {31'b0, q.size() == 16});
    if (q.size() != 0) chk("m_head", rdata_o, q[0]);
  end

  task automatic step(input logic wr, input logic [31:0] wd, input logic rd);
    wren_i = wr; wdata_i = wd; rden_i = rd;
    @(posedge clk); #1;
    wren_i = 0; rden_i = 0;
  endtask

  initial begin
    int pushed, cyc;
    rst_n = 0;
    #2;
    chk("rst_empty", {31'b0, empty_o}, 32'd1);
    chk("rst_full", {31'b0, full_o}, 32'd0);
    chk("rst_rdata", rdata_o, 32'h0);
    @(posedge clk); #1;
    rst_n = 1;
    repeat (5) step(0, 0, 0);
    chk("idle_empty", {31'b0, empty_o}, 32'd1);
    chk("idle_full", {31'b0, full_o}, 32'd0);
    step(1, 32'hA5A5_0001, 0);
    chk("fwft_empty", {31'b0, empty_o}, 32'd0);
    chk("fwft_data", rdata_o, 32'hA5A5_0001);
    step(0, 0, 1);
    chk("fwft_pop_empty", {31'b0, empty_o}, 32'd1);
    for (int i = 0; i < 16; i++) step(1, i, 0);
    chk("fill_full", {31'b0, full_o}, 32'd1);
    step(1, 32'hDEAD, 0);
    chk("ovf_full", {31'b0, full_o}, 32'd1);
    for (int i = 0; i < 16; i++) begin
      chk("drain_order", rdata_o, i);
      step(0, 0, 1);
    end
    chk("drain_empty", {31'b0, empty_o}, 32'd1);
    repeat (3) step(0, 0, 1);
    chk("udf_empty", {31'b0, empty_o}, 32'd1);
    step(1, 32'h1234, 0);
    chk("udf_data", rdata_o, 32'h1234);
    step(0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 100 + i, 0);
    step(1, 200, 1);
    step(1, 201, 1);
    chk("sim5_head", rdata_o, 102);
    for (int i = 0; i < 5; i++) begin
      chk("sim5_order", rdata_o, (i < 3) ? 102 + i : 197 + i);
      step(0, 0, 1);
    end
    chk("sim5_empty", {31'b0, empty_o}, 32'd1);
    step(1, 300, 1);
    chk("sim_e_empty", {31'b0, empty_o}, 32'd0);
    chk("sim_e_data", rdata_o, 300);
    step(0, 0, 1);
    for (int i = 0; i < 16; i++) step(1, 400 + i, 0);
    step(1, 999, 1);
    chk("sim_f_full", {31'b0, full_o}, 32'd0);
    chk("sim_f_head", rdata_o, 401);
    repeat (15) step(0, 0, 1);
    chk("sim_f_empty", {31'b0, empty_o}, 32'd1);
    pushed = 0; cyc = 0;
    while (pushed < 40 && cyc < 1000) begin
      automatic logic w = 1'($urandom_range(0, 1));
      automatic logic r = 1'($urandom_range(0, 1));
      if (w && !full_o) begin
        step(1, 500 + pushed, r);
        pushed++;
      end else step(0, 0, r);
      cyc++;
    end
    chk("stream_done", pushed, 40);
    while (!empty_o && cyc < 1200) begin
      step(0, 0, 1);
      cyc++;
    end
    chk("stream_drained", {31'b0, empty_o}, 32'd1);
    for (int i = 0; i < 3; i++) step(1, 32'hBAD0 + i, 0);
    #2;
    rst_n = 0;
    #1;
    chk("arst_empty", {31'b0, empty_o}, 32'd1);
    chk("arst_full", {31'b0, full_o}, 32'd0);
    chk("arst_rdata", rdata_o, 32'h0);
    @(posedge clk); #1;
    rst_n = 1;
    step(1, 777, 0);
    chk("post_rst_data", rdata_o, 777);
    step(0, 0, 1);
    chk("post_rst_empty", {31'b0, empty_o}, 32'd1);
    repeat (2) step(0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
